rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

N-channel, W-bit round-robin arbitrated multiplexer with a valid/ready handshake on every channel and a registered output stage. It is the parametrised successor to the 1-bit 2:1 gate-level mux. It sits in front of the queue write port and merges several producers into one stream at up to one beat per cycle, with fair arbitration and no dropped data.

## Interface
- DATA_W, 8, data width per channel (>= 1)
- NUM_CH, 4, number of input channels (>= 2, need not be a power of two)
- CH_W, derived = max(1, clog2(NUM_CH)), channel index width (not overridable)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- valid_i  in  NUM_CH  per-channel valid; bit k belongs to channel k
- data_i  in  NUM_CH*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- ready_o  out  NUM_CH  per-channel ready; at most one bit is high
- last_i  in  NUM_CH  per-channel end-of-packet marker; present only with RR_ARB_MUX_LOCK_EN
- valid_o  out  1  output beat valid
- data_o  out  DATA_W  output beat data
- chan_o  out  CH_W  source channel of the current output beat
- ready_i  in  1  downstream ready

## Operation
- Output register: a single entry (data_o, chan_o, valid_o). Load enable: ld = !valid_o | ready_i.
- Arbitration: a combinational search starts at pointer ptr and wraps modulo NUM_CH. The first k with valid_i[k]=1 is the grant g.
- ready_o[k] = ld & (k == g) & valid_i[k]. All other bits are 0. ready_o depends combinationally on ready_i and valid_i.
- Transfer on channel g when valid_i[g] & ready_o[g]:
  - data_o <= data_i[g]
  - chan_o <= g
  - valid_o <= 1
  - ptr <= (g == NUM_CH-1) ? 0 : g+1
- Drain without refill: if valid_o & ready_i and no transfer occurs, valid_o <= 0. data_o and chan_o hold their values.
- No valid input and ld = 1: ptr is unchanged.
- Stall: valid_o=1 & ready_i=0 means all ready_o = 0. data_o and chan_o are stable. ptr is unchanged.
- Producers must hold valid_i and data_i stable until their beat is accepted. The block does not check this.

## Timing
- Latency: accept in cycle n gives valid_o=1 with that data from cycle n+1.
- Throughput: 1 beat per cycle sustained while ready_i=1.
- Fairness: with all channels continuously valid, grants rotate 0,1,...,NUM_CH-1,0. Any waiting channel is served within NUM_CH transfers.
- Simultaneous drain and refill in the same cycle: the refill wins; valid_o stays 1.
- Reset values (asynchronous, immediate on rst_i=1):
  - valid_o=0, data_o=0, chan_o=0, ptr=0
  - lock state IDLE
  - ready_o=0 while rst_i=1
- Reset mid-operation discards any held beat. There is no partial-packet recovery.

## Configuration
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined: the last_i port exists and a 2-state FSM is added.
  - IDLE: arbitrate as above. A transfer from g with last_i[g]=0 moves the FSM to LOCKED(lk=g).
  - LOCKED: g is forced to lk. Other channels see ready_o=0 even if lk is not valid. ptr does not advance.
  - A transfer from lk with last_i[lk]=1 moves the FSM to IDLE and sets ptr <= lk+1 mod NUM_CH.
  - A single-beat packet (last_i=1 on the first beat) never enters LOCKED.
- Not defined: no last_i port, no FSM. Every beat is arbitrated independently.

## Structure
- Package rr_arb_mux_pkg:
  - clog2 function and CH_W derivation
  - lock-state enum (IDLE, LOCKED)
  - next-pointer wrap helper function
- Sub-module rr_pick: combinational round-robin search. Inputs are the request vector and ptr; outputs are grant index g and any-valid. Parametrised on NUM_CH.
- Top level holds the output register, ptr, the ready_o decode and the optional lock FSM.

## Test plan
- Reset: rst_i pulsed mid-stream while valid_o=1 -> valid_o=0, data_o=0, chan_o=0 asynchronously; after release the first grant goes to ch0.
- Round robin: NUM_CH=4, all valid with data 0x10,0x21,0x32,0x43, ready_i=1 -> chan_o sequence 0,1,2,3,0 on consecutive cycles starting at cycle 1.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1, data_o=0x21 -> data_o and chan_o stable, ready_o=0000; ready_i=1 -> the next beat loads in the same cycle.
- Sparse and wrap: NUM_CH=3, only ch2 valid, then only ch0 -> ch2 granted, ptr wraps to 0, ch0 granted next cycle; an idle gap drops valid_o to 0.
- Lock (RR_ARB_MUX_LOCK_EN): ch1 sends 3 beats with last_i=0,0,1 while ch0 and ch2 are valid -> chan_o=1,1,1, then 2; ch1 deasserting valid mid-packet keeps ready_o[0]=ready_o[2]=0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared definitions for the round-robin arbitrated mux.
//   clog2 / ch_width : channel-index width derivation (at least 1 bit)
//   lock_state_e     : packet-lock FSM states (used with RR_ARB_MUX_LOCK_EN)
//   next_ptr         : round-robin pointer advance with wrap at NUM_CH
package rr_arb_mux_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single-channel index still needs one bit so the port never collapses.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Channel after g, wrapping to 0 (NUM_CH need not be a power of two).
  function automatic int next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: handshake bundle between the producers, the arbiter and
// the downstream consumer.
//   valid_i/data_i/last_i : per-channel producer side (last_i only when
//                           RR_ARB_MUX_LOCK_EN is defined)
//   ready_o               : per-channel acceptance, at most one bit high
//   valid_o/data_o/chan_o : registered output beat and its source channel
//   ready_i               : downstream ready
// Modports: master = arbiter side, slave = environment side.
interface rr_arb_mux_if import rr_arb_mux_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) ();
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]        valid_i;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        ready_o;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [NUM_CH-1:0]        last_i;
`endif
  logic                     valid_o;
  logic [DATA_W-1:0]        data_o;
  logic [CH_W-1:0]          chan_o;
  logic                     ready_i;

`ifdef RR_ARB_MUX_LOCK_EN
  modport master (input valid_i, data_i, last_i, ready_i,
                  output ready_o, valid_o, data_o, chan_o);
  modport slave  (output valid_i, data_i, last_i, ready_i,
                  input ready_o, valid_o, data_o, chan_o);
`else
  modport master (input valid_i, data_i, ready_i,
                  output ready_o, valid_o, data_o, chan_o);
  modport slave  (output valid_i, data_i, ready_i,
                  input ready_o, valid_o, data_o, chan_o);
`endif
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
//   req   : request vector, bit k = channel k
//   ptr   : first channel to consider (must be < NUM_CH)
//   grant : first requesting channel at or after ptr, wrapping modulo NUM_CH
//   any   : at least one request present (grant is 0 otherwise)
module rr_pick import rr_arb_mux_pkg::*; #(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  logic [CH_W-1:0] idx;
  int              sum;

  // Walk offsets from farthest to nearest so the closest requester to ptr
  // is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH x DATA_W round-robin arbitrated mux with a single
// registered output beat.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : rr_arb_mux_if.master (per-channel valid/data/ready, optional
//           last_i, output valid/data/chan, downstream ready)
// Optional feature macro: RR_ARB_MUX_LOCK_EN -- once a channel starts a
// multi-beat packet (last_i=0) it keeps the grant until its last_i=1 beat.
module rr_arb_mux import rr_arb_mux_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rr_arb_mux_if.master   bus
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [CH_W-1:0]   ptr_reg;
  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CH_W-1:0]   chan_reg;
`ifdef RR_ARB_MUX_LOCK_EN
  lock_state_e       state_reg;
  logic [CH_W-1:0]   lk_reg;
`endif

  logic [CH_W-1:0]   pick_grant;
  logic              pick_any;
  logic [CH_W-1:0]   g;
  logic              g_valid;
  logic              ld;
  logic              xfer;
  logic [CH_W-1:0]   ptr_next;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
    assign ch_data[gi] = bus.data_i[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (bus.valid_i),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_comb begin
    g       = pick_grant;
    g_valid = pick_any;
`ifdef RR_ARB_MUX_LOCK_EN
    // A locked packet owns the output even while its producer idles.
    if (state_reg == LOCKED) begin
      g       = lk_reg;
      g_valid = bus.valid_i[lk_reg];
    end
`endif
  end

  // The output slot can take a beat when it is empty or being drained now.
  assign ld       = !valid_reg || bus.ready_i;
  // rst_i gating keeps ready_o low for the whole reset pulse.
  assign xfer     = ld && g_valid && !rst_i;
  assign ptr_next = CH_W'(next_ptr(int'(g), NUM_CH));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
    assign bus.ready_o[gi] = xfer && (g == CH_W'(gi));
  end

  assign bus.valid_o = valid_reg;
  assign bus.data_o  = data_reg;
  assign bus.chan_o  = chan_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      chan_reg  <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      state_reg <= IDLE;
      lk_reg    <= '0;
`endif
    end else begin
      if (xfer) begin
        data_reg  <= ch_data[g];
        chan_reg  <= g;
        valid_reg <= 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        if (state_reg == IDLE) begin
          ptr_reg <= ptr_next;
          if (!bus.last_i[g]) begin
            state_reg <= LOCKED;
            lk_reg    <= g;
          end
        end else if (bus.last_i[g]) begin
          // End of packet: resume rotation just after the locked channel.
          state_reg <= IDLE;
          ptr_reg   <= ptr_next;
        end
`else
        ptr_reg <= ptr_next;
`endif
      end else if (bus.ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_arb_mux_if #(.DATA_W(8), .NUM_CH(4)) bus4 ();
  rr_arb_mux_if #(.DATA_W(8), .NUM_CH(3)) bus3 ();

  rr_arb_mux #(.DATA_W(8), .NUM_CH(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  rr_arb_mux #(.DATA_W(8), .NUM_CH(3)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus4.valid_i = 4'hF;
    bus4.data_i  = 32'h43_32_21_10;
    bus4.ready_i = 1'b1;
    #1;
    total++; if (bus4.ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", bus4.ready_o); end
    total++; if (bus4.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus4.valid_o); end
    total++; if (bus4.data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus4.data_o); end
    total++; if (bus4.chan_o !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d want=0", bus4.chan_o); end
    rst = 1'b0;
    #1;
    total++; if (bus4.ready_o !== 4'b0001) begin bad++; $display("FAIL post_reset_ready got=%b want=0001", bus4.ready_o); end
    $display("reset released ready_o=%b", bus4.ready_o);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("rr beat %0d chan=%0d data=%h", k, bus4.chan_o, bus4.data_o);
      total++; if (bus4.valid_o !== 1'b1) begin bad++; $display("FAIL rr_valid beat=%0d got=%b want=1", k, bus4.valid_o); end
      total++; if (bus4.chan_o !== 2'(k % 4)) begin bad++; $display("FAIL rr_chan beat=%0d got=%0d want=%0d", k, bus4.chan_o, k % 4); end
      total++; if (bus4.data_o !== exp_data[k % 4]) begin bad++; $display("FAIL rr_data beat=%0d got=%h want=%h", k, bus4.data_o, exp_data[k % 4]); end
    end
  endtask

  task automatic test_backpressure();
    tick();
    total++; if (bus4.data_o !== 8'h21 || bus4.chan_o !== 2'd1) begin bad++; $display("FAIL bp_pre got=%h/%0d want=21/1", bus4.data_o, bus4.chan_o); end
    bus4.ready_i = 1'b0;
    #1;
    total++; if (bus4.ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready_comb got=%b want=0000", bus4.ready_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("stall %0d chan=%0d data=%h ready_o=%b", k, bus4.chan_o, bus4.data_o, bus4.ready_o);
      total++; if (bus4.data_o !== 8'h21 || bus4.chan_o !== 2'd1 || bus4.valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%0d/%b want=21/1/1", k, bus4.data_o, bus4.chan_o, bus4.valid_o); end
      total++; if (bus4.ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0000", k, bus4.ready_o); end
    end
    bus4.ready_i = 1'b1;
    #1;
    total++; if (bus4.ready_o !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b want=0100", bus4.ready_o); end
    tick();
    $display("release chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.data_o !== 8'h32 || bus4.chan_o !== 2'd2) begin bad++; $display("FAIL bp_release got=%h/%0d want=32/2", bus4.data_o, bus4.chan_o); end
  endtask

  task automatic test_midstream_reset();
    rst = 1'b1;
    #1;
    total++; if (bus4.valid_o !== 1'b0 || bus4.data_o !== 8'h00 || bus4.chan_o !== 2'd0) begin bad++; $display("FAIL async_reset got=%b/%h/%0d want=0/00/0", bus4.valid_o, bus4.data_o, bus4.chan_o); end
    rst = 1'b0;
    #1;
    tick();
    $display("after reset chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd0 || bus4.data_o !== 8'h10 || bus4.valid_o !== 1'b1) begin bad++; $display("FAIL reset_first_grant got=%0d/%h/%b want=0/10/1", bus4.chan_o, bus4.data_o, bus4.valid_o); end
  endtask

  task automatic test_idle_gap();
    bus4.valid_i = 4'b0000;
    tick();
    total++; if (bus4.valid_o !== 1'b0 || bus4.data_o !== 8'h10 || bus4.chan_o !== 2'd0) begin bad++; $display("FAIL drain got=%b/%h/%0d want=0/10/0", bus4.valid_o, bus4.data_o, bus4.chan_o); end
    bus4.valid_i = 4'b1001;
    #1;
    total++; if (bus4.ready_o !== 4'b1000) begin bad++; $display("FAIL idle_ptr_hold got=%b want=1000", bus4.ready_o); end
    tick();
    $display("gap beat chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd3 || bus4.data_o !== 8'h43) begin bad++; $display("FAIL gap_beat got=%0d/%h want=3/43", bus4.chan_o, bus4.data_o); end
    bus4.valid_i = 4'b0000;
    tick();
    total++; if (bus4.valid_o !== 1'b0) begin bad++; $display("FAIL gap_drain got=%b want=0", bus4.valid_o); end
  endtask

  task automatic test_sparse_wrap();
    bus3.ready_i = 1'b1;
    bus3.data_i  = 24'hC2_B1_A0;
    bus3.valid_i = 3'b100;
    #1;
    total++; if (bus3.ready_o !== 3'b100) begin bad++; $display("FAIL sparse_ready2 got=%b want=100", bus3.ready_o); end
    tick();
    $display("n3 beat chan=%0d data=%h", bus3.chan_o, bus3.data_o);
    total++; if (bus3.chan_o !== 2'd2 || bus3.data_o !== 8'hC2 || bus3.valid_o !== 1'b1) begin bad++; $display("FAIL sparse_beat2 got=%0d/%h/%b want=2/c2/1", bus3.chan_o, bus3.data_o, bus3.valid_o); end
    bus3.valid_i = 3'b011;
    #1;
    total++; if (bus3.ready_o !== 3'b001) begin bad++; $display("FAIL wrap_ready got=%b want=001", bus3.ready_o); end
    tick();
    $display("n3 beat chan=%0d data=%h", bus3.chan_o, bus3.data_o);
    total++; if (bus3.chan_o !== 2'd0 || bus3.data_o !== 8'hA0) begin bad++; $display("FAIL wrap_beat got=%0d/%h want=0/a0", bus3.chan_o, bus3.data_o); end
    bus3.valid_i = 3'b000;
    tick();
    total++; if (bus3.valid_o !== 1'b0) begin bad++; $display("FAIL n3_drain got=%b want=0", bus3.valid_o); end
  endtask

`ifdef RR_ARB_MUX_LOCK_EN
  task automatic test_lock();
    bus4.data_i  = 32'h00_32_21_10;
    bus4.last_i  = 4'b0101;
    bus4.valid_i = 4'b0111;
    tick();
    total++; if (bus4.chan_o !== 2'd0) begin bad++; $display("FAIL lock_pre got=%0d want=0", bus4.chan_o); end
    tick();
    $display("lock beat chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd1 || bus4.data_o !== 8'h21) begin bad++; $display("FAIL lock_b0 got=%0d/%h want=1/21", bus4.chan_o, bus4.data_o); end
    bus4.data_i = 32'h00_32_22_10;
    tick();
    $display("lock beat chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd1 || bus4.data_o !== 8'h22) begin bad++; $display("FAIL lock_b1 got=%0d/%h want=1/22", bus4.chan_o, bus4.data_o); end
    bus4.valid_i = 4'b0101;
    #1;
    total++; if (bus4.ready_o !== 4'b0000) begin bad++; $display("FAIL lock_others got=%b want=0000", bus4.ready_o); end
    tick();
    total++; if (bus4.valid_o !== 1'b0) begin bad++; $display("FAIL lock_gap got=%b want=0", bus4.valid_o); end
    bus4.data_i  = 32'h00_32_23_10;
    bus4.last_i  = 4'b0111;
    bus4.valid_i = 4'b0111;
    #1;
    total++; if (bus4.ready_o !== 4'b0010) begin bad++; $display("FAIL lock_resume got=%b want=0010", bus4.ready_o); end
    tick();
    $display("lock beat chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd1 || bus4.data_o !== 8'h23) begin bad++; $display("FAIL lock_b2 got=%0d/%h want=1/23", bus4.chan_o, bus4.data_o); end
    tick();
    $display("unlock beat chan=%0d data=%h", bus4.chan_o, bus4.data_o);
    total++; if (bus4.chan_o !== 2'd2 || bus4.data_o !== 8'h32) begin bad++; $display("FAIL unlock got=%0d/%h want=2/32", bus4.chan_o, bus4.data_o); end
    bus4.valid_i = 4'b0000;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus4.valid_i = '0;
    bus4.data_i  = '0;
    bus4.ready_i = 1'b0;
    bus3.valid_i = '0;
    bus3.data_i  = '0;
    bus3.ready_i = 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
    bus4.last_i  = '1;
    bus3.last_i  = '1;
`endif
    repeat (2) tick();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_midstream_reset();
    test_idle_gap();
    test_sparse_wrap();
`ifdef RR_ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
